snake_body_engine: RTL and testbench

Parametrised snake movement engine that keeps body segment grid coordinates in an internal circular buffer. It advances the snake one cell per `step` pulse, detects wall and self collisions, and streams the changed pixels to the frame-buffer writer. Body length, grid size, cell size and colours are generic. Growth is a pointer operation rather than a queue shift.

---
 rtl/snake_body_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake movement engine: circular segment buffer, wall/self collision checks,
// and a per-cell pixel stream for the frame-buffer writer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | load initial segments and draw them (head first)
// IDLE     | wait for step
// CALC     | compute next head, wall check
// SCAN     | compare next head with stored segments, head towards tail
// ERASE    | draw tail cell in background, advance tail pointer
// RECOLOUR | redraw old head in body colour
// WRITE    | advance head pointer, store new head, update length
// DRAW     | draw new head in head colour
// DONE     | one-cycle completion pulse
// DEAD     | collision latched, frozen until restart/reset
module snake_body_engine #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int CELL = 4,
  parameter int MAX_LEN = 64,
  parameter int INIT_LEN = 3,
  parameter logic [2:0] HEAD_COLOUR = 3'b100,
  parameter logic [2:0] BODY_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  localparam int CX_W = $clog2(GRID_W),
  localparam int CY_W = $clog2(GRID_H),
  localparam int PX_W = $clog2(GRID_W * CELL),
  localparam int PY_W = $clog2(GRID_H * CELL),
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic [1:0]      dir,
  input  logic            grow,
  input  logic            restart,
  output logic            busy,
  output logic            done,
  output logic            dead,
  output logic [LEN_W-1:0] length,
  output logic [CX_W-1:0] head_x,
  output logic [CY_W-1:0] head_y,
  output logic [PX_W-1:0] pix_x,
  output logic [PY_W-1:0] pix_y,
  output logic [2:0]      pix_colour,
  output logic            pix_valid
);

  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PC_W = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_CALC, S_SCAN, S_ERASE,
    S_RECOLOUR, S_WRITE, S_DRAW, S_DONE, S_DEAD
  } state_t;

  state_t state, state_nxt;

  logic [CX_W-1:0] seg_x [MAX_LEN];
  logic [CY_W-1:0] seg_y [MAX_LEN];

  logic [PTR_W-1:0] head_ptr, tail_ptr, scan_ptr;
  logic [LEN_W-1:0] scan_left, init_idx;
  logic [1:0] cur_dir;
  logic grow_q;
  logic [CX_W-1:0] nx, calc_x, cell_x;
  logic [CY_W-1:0] ny, calc_y, cell_y;
  logic [PC_W-1:0] dx, dy;
  logic [2:0] cell_colour;
  logic drawing, last_pix, wall, hit, dir_opposite;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(MAX_LEN - 1) : p - 1'b1;
  endfunction

  assign busy = (state != S_IDLE) && (state != S_DEAD);
  assign done = (state == S_DONE);
  assign dead = (state == S_DEAD);

  assign last_pix = (dx == PC_W'(CELL - 1)) && (dy == PC_W'(CELL - 1));
  assign hit = (seg_x[scan_ptr] == nx) && (seg_y[scan_ptr] == ny);
  assign dir_opposite = (dir[1] == cur_dir[1]) && (dir[0] != cur_dir[0]);

  always_comb begin
    wall = 1'b0;
    calc_x = head_x;
    calc_y = head_y;
    case (cur_dir)
      2'b00: if (head_x == CX_W'(GRID_W - 1)) wall = 1'b1; else calc_x = head_x + 1'b1;
      2'b01: if (head_x == '0) wall = 1'b1; else calc_x = head_x - 1'b1;
      2'b10: if (head_y == '0) wall = 1'b1; else calc_y = head_y - 1'b1;
      2'b11: if (head_y == CY_W'(GRID_H - 1)) wall = 1'b1; else calc_y = head_y + 1'b1;
      default: wall = 1'b0;
    endcase
  end

  // Cell currently being painted and its colour, selected by state.
  always_comb begin
    drawing = 1'b0;
    cell_x = '0;
    cell_y = '0;
    cell_colour = BG_COLOUR;
    case (state)
      S_INIT: begin
        drawing = 1'b1;
        cell_x = CX_W'(GRID_W / 2) - CX_W'(init_idx);
        cell_y = CY_W'(GRID_H / 2);
        cell_colour = (init_idx == '0) ? HEAD_COLOUR : BODY_COLOUR;
      end
      S_ERASE: begin
        drawing = 1'b1;
        cell_x = seg_x[tail_ptr];
        cell_y = seg_y[tail_ptr];
        cell_colour = BG_COLOUR;
      end
      S_RECOLOUR: begin
        drawing = 1'b1;
        cell_x = seg_x[head_ptr];
        cell_y = seg_y[head_ptr];
        cell_colour = BODY_COLOUR;
      end
      S_DRAW: begin
        drawing = 1'b1;
        cell_x = nx;
        cell_y = ny;
        cell_colour = HEAD_COLOUR;
      end
      default: drawing = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     if (last_pix && init_idx == LEN_W'(INIT_LEN - 1)) state_nxt = S_IDLE;
      S_IDLE:     if (step) state_nxt = S_CALC;
      S_CALC:     state_nxt = wall ? S_DEAD : S_SCAN;
      S_SCAN: begin
        if (hit) state_nxt = S_DEAD;
        else if (scan_left == LEN_W'(1)) state_nxt = grow_q ? S_RECOLOUR : S_ERASE;
      end
      S_ERASE:    if (last_pix) state_nxt = S_RECOLOUR;
      S_RECOLOUR: if (last_pix) state_nxt = S_WRITE;
      S_WRITE:    state_nxt = S_DRAW;
      S_DRAW:     if (last_pix) state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      S_DEAD:     state_nxt = S_DEAD;
      default:    state_nxt = S_INIT;
    endcase
    if (restart) state_nxt = S_INIT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else state <= state_nxt;
  end

  // Segment store is not reset: INIT rewrites every live entry.
  always_ff @(posedge clk) begin
    if (!restart) begin
      if (state == S_INIT) begin
        seg_x[PTR_W'(INIT_LEN - 1) - PTR_W'(init_idx)] <= cell_x;
        seg_y[PTR_W'(INIT_LEN - 1) - PTR_W'(init_idx)] <= cell_y;
      end else if (state == S_WRITE) begin
        seg_x[ptr_inc(head_ptr)] <= nx;
        seg_y[ptr_inc(head_ptr)] <= ny;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr   <= PTR_W'(INIT_LEN - 1);
      tail_ptr   <= '0;
      scan_ptr   <= '0;
      scan_left  <= '0;
      init_idx   <= '0;
      length     <= LEN_W'(INIT_LEN);
      cur_dir    <= 2'b00;
      grow_q     <= 1'b0;
      nx         <= '0;
      ny         <= '0;
      dx         <= '0;
      dy         <= '0;
      head_x     <= CX_W'(GRID_W / 2);
      head_y     <= CY_W'(GRID_H / 2);
      pix_x      <= '0;
      pix_y      <= '0;
      pix_colour <= '0;
      pix_valid  <= 1'b0;
    end else if (restart) begin
      head_ptr  <= PTR_W'(INIT_LEN - 1);
      tail_ptr  <= '0;
      init_idx  <= '0;
      length    <= LEN_W'(INIT_LEN);
      cur_dir   <= 2'b00;
      grow_q    <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      head_x    <= CX_W'(GRID_W / 2);
      head_y    <= CY_W'(GRID_H / 2);
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= drawing;
      if (drawing) begin
        pix_x      <= PX_W'(cell_x) * PX_W'(CELL) + PX_W'(dx);
        pix_y      <= PY_W'(cell_y) * PY_W'(CELL) + PY_W'(dy);
        pix_colour <= cell_colour;
        if (dx == PC_W'(CELL - 1)) begin
          dx <= '0;
          dy <= (dy == PC_W'(CELL - 1)) ? '0 : dy + 1'b1;
        end else begin
          dx <= dx + 1'b1;
        end
      end
      case (state)
        S_INIT: if (last_pix) init_idx <= init_idx + 1'b1;
        S_IDLE: begin
          if (step) begin
            grow_q <= grow && (length != LEN_W'(MAX_LEN));
            if (!dir_opposite) cur_dir <= dir;
          end
        end
        S_CALC: begin
          nx        <= calc_x;
          ny        <= calc_y;
          scan_ptr  <= head_ptr;
          // The tail vacates on a plain move, so it cannot be hit.
          scan_left <= grow_q ? length : length - 1'b1;
        end
        S_SCAN: begin
          scan_ptr  <= ptr_dec(scan_ptr);
          scan_left <= scan_left - 1'b1;
        end
        S_ERASE: if (last_pix) tail_ptr <= ptr_inc(tail_ptr);
        S_WRITE: begin
          head_ptr <= ptr_inc(head_ptr);
          head_x   <= nx;
          head_y   <= ny;
          if (grow_q) length <= length + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: stimulus pushes expected pixels and
// move completions, a monitor pops and compares whenever the DUT presents them.
module tb_snake_body_engine;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int CELL = 4;
  localparam int MAX_LEN = 64;
  localparam int INIT_LEN = 3;
  localparam int HEAD = 4;
  localparam int BODY = 7;
  localparam int BG = 0;

  logic clk = 1'b0;
  logic rst, step, grow, restart;
  logic [1:0] dir;
  logic busy, done, dead, pix_valid;
  logic [6:0] length;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow), .restart(restart),
    .busy(busy), .done(done), .dead(dead), .length(length),
    .head_x(head_x), .head_y(head_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { int hx; int hy; int len; } move_t;

  pix_t  exp_pix [$];
  move_t exp_done [$];
  int errors = 0;
  int checks = 0;

  // Reference snake: index 0 is the head.
  int mx [$];
  int my [$];
  logic [1:0] m_dir;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_cell(input int cx, input int cy, input int col);
    for (int yy = 0; yy < CELL; yy++)
      for (int xx = 0; xx < CELL; xx++)
        exp_pix.push_back('{cx * CELL + xx, cy * CELL + yy, col});
  endtask

  task automatic model_init();
    mx.delete();
    my.delete();
    m_dir = 2'b00;
    for (int k = 0; k < INIT_LEN; k++) begin
      mx.push_back(GRID_W / 2 - k);
      my.push_back(GRID_H / 2);
      push_cell(GRID_W / 2 - k, GRID_H / 2, (k == 0) ? HEAD : BODY);
    end
  endtask

  // Monitor: samples 1 unit after the active edge.
  pix_t  mp;
  move_t md;
  always @(posedge clk) begin
    #1;
    if (rst && pix_valid) begin
      if (exp_pix.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0d, required none", pix_x, pix_y, pix_colour);
      end else begin
        mp = exp_pix.pop_front();
        check("pix_x", pix_x, mp.x);
        check("pix_y", pix_y, mp.y);
        check("pix_colour", pix_colour, mp.c);
      end
    end
    if (rst && done) begin
      if (exp_done.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_done: got done=1, required 0");
      end else begin
        md = exp_done.pop_front();
        check("done_head_x", head_x, md.hx);
        check("done_head_y", head_y, md.hy);
        check("done_length", length, md.len);
      end
    end
  end

  task automatic wait_init();
    int cnt = 0;
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("init_cycles", cnt, INIT_LEN * CELL * CELL);
    check("init_pixels_left", exp_pix.size(), 0);
    check("init_length", length, INIT_LEN);
    check("init_head_x", head_x, GRID_W / 2);
    check("init_head_y", head_y, GRID_H / 2);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    exp_pix.delete();
    exp_done.delete();
    model_init();
    @(negedge clk);
    restart = 1'b0;
    check("restart_pix_valid", pix_valid, 0);
    check("restart_dead", dead, 0);
    check("restart_busy", busy, 1);
    wait_init();
  endtask

  task automatic do_move(input logic [1:0] d, input bit g);
    int len, nxv, nyv, lanes, exp_lat, cnt, hit_i;
    bit wall, hit, ge, m_dead;
    len = mx.size();
    if (!(d[1] == m_dir[1] && d[0] != m_dir[0])) m_dir = d;
    ge = g && (len < MAX_LEN);
    nxv = mx[0];
    nyv = my[0];
    wall = 1'b0;
    case (m_dir)
      2'b00: if (nxv == GRID_W - 1) wall = 1'b1; else nxv++;
      2'b01: if (nxv == 0) wall = 1'b1; else nxv--;
      2'b10: if (nyv == 0) wall = 1'b1; else nyv--;
      default: if (nyv == GRID_H - 1) wall = 1'b1; else nyv++;
    endcase
    lanes = ge ? len : len - 1;
    hit = 1'b0;
    hit_i = 0;
    if (!wall)
      for (int i = 0; i < lanes; i++)
        if (!hit && mx[i] == nxv && my[i] == nyv) begin
          hit = 1'b1;
          hit_i = i;
        end
    m_dead = wall || hit;
    if (wall) exp_lat = 2;
    else if (hit) exp_lat = 3 + hit_i;
    else begin
      exp_lat = 1 + lanes + (ge ? 0 : CELL * CELL) + CELL * CELL + 1 + CELL * CELL + 1;
      if (!ge) push_cell(mx[len - 1], my[len - 1], BG);
      push_cell(mx[0], my[0], BODY);
      push_cell(nxv, nyv, HEAD);
      mx.push_front(nxv);
      my.push_front(nyv);
      if (!ge) begin
        void'(mx.pop_back());
        void'(my.pop_back());
      end
      exp_done.push_back('{nxv, nyv, mx.size()});
    end
    @(negedge clk);
    dir = d;
    grow = g;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    grow = 1'b0;
    cnt = 1;
    while (!done && !dead && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("move_latency", cnt, exp_lat);
    check("move_dead", dead, m_dead);
    if (m_dead) check("dead_busy", busy, 0);
    else begin
      @(negedge clk);
      check("done_pulse_width", done, 0);
    end
  endtask

  task automatic dead_hold();
    @(negedge clk);
    dir = 2'b11;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (60) @(negedge clk);
    check("hold_dead", dead, 1);
    check("hold_busy", busy, 0);
    check("hold_head_x", head_x, mx[0]);
    check("hold_head_y", head_y, my[0]);
    check("hold_length", length, mx.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    step = 1'b0;
    dir = 2'b00;
    grow = 1'b0;
    restart = 1'b0;
    #23;
    check("rst_busy", busy, 1);
    check("rst_done", done, 0);
    check("rst_dead", dead, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_pix_colour", pix_colour, 0);
    check("rst_length", length, 3);
    check("rst_head_x", head_x, 20);
    check("rst_head_y", head_y, 15);
    @(negedge clk);
    model_init();
    rst = 1'b1;
    wait_init();

    // Plain move, grow, and an ignored reversal.
    do_move(2'b00, 1'b0);
    check("m1_head_x", head_x, 21);
    check("m1_length", length, 3);
    do_move(2'b00, 1'b1);
    check("grow_length", length, 4);
    do_move(2'b01, 1'b0);
    check("reverse_ignored_x", head_x, 23);
    do_move(2'b00, 1'b1);
    check("len5", length, 5);
    // Down, left, up onto the body.
    do_move(2'b11, 1'b0);
    do_move(2'b01, 1'b0);
    do_move(2'b10, 1'b0);
    check("self_hit_dead", dead, 1);
    dead_hold();
    do_restart();

    // Square loop onto the vacating tail.
    do_move(2'b00, 1'b1);
    do_move(2'b11, 1'b0);
    do_move(2'b01, 1'b0);
    do_move(2'b10, 1'b0);
    check("tail_chase_alive", dead, 0);
    check("tail_chase_x", head_x, 20);
    check("tail_chase_y", head_y, 15);
    do_move(2'b00, 1'b1);
    check("tail_grow_dead", dead, 1);
    do_restart();

    // Right wall.
    repeat (19) do_move(2'b00, 1'b0);
    check("wall_head_x", head_x, 39);
    do_move(2'b00, 1'b0);
    check("wall_dead", dead, 1);
    dead_hold();
    do_restart();

    // Grow to full length, then keep moving past a full pointer lap.
    repeat (18) do_move(2'b00, 1'b1);
    do_move(2'b11, 1'b1);
    repeat (36) do_move(2'b01, 1'b1);
    do_move(2'b11, 1'b1);
    repeat (5) do_move(2'b00, 1'b1);
    check("full_length", length, 64);
    do_move(2'b00, 1'b1);
    check("full_grow_clamped", length, 64);
    repeat (30) do_move(2'b00, 1'b0);
    do_move(2'b11, 1'b0);
    repeat (36) do_move(2'b01, 1'b0);
    check("wrap_length", length, 64);
    check("wrap_head_x", head_x, 2);
    check("wrap_head_y", head_y, 18);
    do_restart();

    // Restart in the middle of drawing the new head.
    push_cell(18, 15, BG);
    push_cell(20, 15, BODY);
    push_cell(21, 15, HEAD);
    @(negedge clk);
    dir = 2'b00;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    begin
      int cnt = 0;
      while (exp_pix.size() > 10 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      check("mid_draw_reached", (exp_pix.size() <= 10) ? 1 : 0, 1);
    end
    do_restart();

    repeat (5) @(negedge clk);
    check("end_pixels_left", exp_pix.size(), 0);
    check("end_done_left", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
